// File: rtl/f_add_unit.sv
// rtl/f_add_unit.sv - registered ripple-carry full adder, WIDTH-bit operands plus carry-in
module f_add_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             O,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;
    logic             valid_q;

    // Ripple chain of single-bit full-adder cells.
    always_comb begin
        c     = '0;
        sum_d = '0;
        c[0]  = C;
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i] = A[i] ^ B[i] ^ c[i];
            c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        carry_d = c[WIDTH];
    end

    // Sum/carry hold when no input is accepted; valid drops to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end
    end

    assign S         = sum_q;
    assign O         = carry_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_f_add_unit.sv
// tb/tb_f_add_unit.sv - scoreboard bench for f_add_unit at WIDTH=1 and WIDTH=4
module tb_f_add_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] s1;
    logic       o1;
    logic       v1;
    logic [3:0] s4;
    logic       o4;
    logic       v4;

    int checks   = 0;
    int failures = 0;

    // {v1, o1, s1, v4, o4, s4}
    logic [8:0] exp_q[$];
    logic [8:0] exp_v;
    logic [8:0] obs;

    logic       m_v;
    logic       m_o1;
    logic       m_s1;
    logic       m_o4;
    logic [3:0] m_s4;

    assign a1 = a4[0:0];
    assign b1 = b4[0:0];

    always #5 clk = ~clk;

    f_add_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .C(cin), .in_valid(in_valid),
        .S(s1), .O(o1), .out_valid(v1)
    );

    f_add_unit #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .C(cin), .in_valid(in_valid),
        .S(s4), .O(o4), .out_valid(v4)
    );

    function automatic logic [8:0] observe();
        return {v1, o1, s1, v4, o4, s4};
    endfunction

    // Drives one cycle of stimulus, advances the reference model, pushes the
    // expected registered outputs, and returns at the following falling edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic ci);
        logic [4:0] full4;
        logic [1:0] full1;
        rst      = r;
        in_valid = v;
        a4       = a;
        b4       = b;
        cin      = ci;
        full4 = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        full1 = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, ci};
        if (r) begin
            m_v = 1'b0; m_o1 = 1'b0; m_s1 = 1'b0; m_o4 = 1'b0; m_s4 = 4'h0;
        end else begin
            m_v = v;
            if (v) begin
                {m_o4, m_s4} = full4;
                {m_o1, m_s1} = full1;
            end
        end
        exp_q.push_back({m_v, m_o1, m_s1, m_v, m_o4, m_s4});
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 4'h1, 4'h1, 1'b1);
            exp_v = exp_q.pop_front();
            obs   = observe();
            checks++;
            if (obs !== exp_v || obs !== 9'h0) begin
                failures++;
                $display("FAIL reset cycle %0d: got %h want %h", i, obs, exp_v);
            end
        end
        drive(1'b0, 1'b1, 4'h1, 4'h1, 1'b1);
        exp_v = exp_q.pop_front();
        obs   = observe();
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_release: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] want [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int k = 0; k < 8; k++) begin
            logic [2:0] abc;
            abc = 3'(k);
            drive(1'b0, 1'b1, {3'b0, abc[2]}, {3'b0, abc[1]}, abc[0]);
            exp_v = exp_q.pop_front();
            obs   = observe();
            checks++;
            if (obs !== exp_v || {v1, o1, s1} !== {1'b1, want[k]}) begin
                failures++;
                $display("FAIL truth_table abc=%b: got v,o,s=%b%b%b want 1%b (model %h obs %h)",
                         abc, v1, o1, s1, want[k], exp_v, obs);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 4'h1, 4'h1, 1'b1);
        exp_v = exp_q.pop_front();
        obs   = observe();
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL hold_load: got %h want %h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            exp_v = exp_q.pop_front();
            obs   = observe();
            checks++;
            if (obs !== exp_v || {v1, o1, s1} !== 3'b011) begin
                failures++;
                $display("FAIL hold cycle %0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_wide();
        logic [3:0] wa [3] = '{4'hF, 4'hF, 4'h5};
        logic [3:0] wb [3] = '{4'h1, 4'hF, 4'hA};
        logic       wc [3] = '{1'b0, 1'b1, 1'b0};
        logic [4:0] ws [3] = '{5'h10, 5'h1F, 5'h0F};
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, wa[k], wb[k], wc[k]);
            exp_v = exp_q.pop_front();
            obs   = observe();
            checks++;
            if (obs !== exp_v || {v4, o4, s4} !== {1'b1, ws[k]}) begin
                failures++;
                $display("FAIL wide case %0d: got o,s=%b,%h want %b,%h", k, o4, s4,
                         ws[k][4], ws[k][3:0]);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 200; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            exp_v = exp_q.pop_front();
            obs   = observe();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random cycle %0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b0, 1'b1, 4'h7, 4'h6, 1'b1);
        exp_v = exp_q.pop_front();
        obs   = observe();
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL midstream_pre: got %h want %h", obs, exp_v);
        end
        drive(1'b1, 1'b1, 4'h1, 4'h0, 1'b0);
        exp_v = exp_q.pop_front();
        obs   = observe();
        checks++;
        if (obs !== exp_v || obs !== 9'h0) begin
            failures++;
            $display("FAIL midstream_reset: got %h want %h", obs, exp_v);
        end
        drive(1'b0, 1'b1, 4'h1, 4'h0, 1'b0);
        exp_v = exp_q.pop_front();
        obs   = observe();
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL midstream_resume: got %h want %h", obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a4 = '0; b4 = '0; cin = 1'b0;
        m_v = 1'b0; m_o1 = 1'b0; m_s1 = 1'b0; m_o4 = 1'b0; m_s4 = '0;
        test_reset();
        test_truth_table();
        test_hold();
        test_wide();
        test_back_to_back_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
